// File: rtl/vga_layer_mixer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_layer_mixer : two-stage priority compositor of overlay layers with      |
// |                   blink/XOR modes and matching sync delay.  Rev 1.0         |
// +-----------------------------------------------------------------------------+
module vga_layer_mixer #(
    parameter int NUM_LAYERS   = 10,
    parameter int COLOR_W      = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pixel_tick,
    input  logic                          frame_start,
    input  logic                          video_on,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic [NUM_LAYERS-1:0]         layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [2*NUM_LAYERS-1:0]       layer_mode,
    input  logic [COLOR_W-1:0]            bg_rgb,
    output logic [COLOR_W-1:0]            rgb,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          blink_phase
);

    localparam int               c_cnt_w      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLINK_FRAMES - 1);
    localparam logic [1:0]       c_mode_blink = 2'b01;
    localparam logic [1:0]       c_mode_xor   = 2'b10;
    localparam logic [1:0]       c_mode_off   = 2'b11;

    logic [c_cnt_w-1:0]          r_frame_cnt;
    logic                        r_blink_phase;

    logic                        r_video;
    logic                        r_hsync;
    logic                        r_vsync;
    logic [NUM_LAYERS-1:0]       r_on;
    logic [NUM_LAYERS*COLOR_W-1:0] r_rgb;
    logic [2*NUM_LAYERS-1:0]     r_mode;

    logic [COLOR_W-1:0]          r_out_rgb;
    logic                        r_out_hsync;
    logic                        r_out_vsync;

    logic [COLOR_W-1:0]          w_acc;
    logic [COLOR_W-1:0]          w_rgb_next;

    // Blink engine runs on every clk, independent of the pixel enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (frame_start) begin
            if (r_frame_cnt == c_cnt_last) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_video <= 1'b0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_on    <= '0;
            r_rgb   <= '0;
            r_mode  <= '0;
        end else if (pixel_tick) begin
            r_video <= video_on;
            r_hsync <= hsync_in;
            r_vsync <= vsync_in;
            r_on    <= layer_on;
            r_rgb   <= layer_rgb;
            r_mode  <= layer_mode;
        end
    end

    // Bottom-up walk: later (higher) layers overwrite or XOR into the result.
    always_comb begin
        w_acc = bg_rgb;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (r_on[i] && (r_mode[2*i +: 2] != c_mode_off) &&
                ((r_mode[2*i +: 2] != c_mode_blink) || r_blink_phase)) begin
                if (r_mode[2*i +: 2] == c_mode_xor)
                    w_acc = w_acc ^ r_rgb[i*COLOR_W +: COLOR_W];
                else
                    w_acc = r_rgb[i*COLOR_W +: COLOR_W];
            end
        end
        w_rgb_next = r_video ? w_acc : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_rgb   <= '0;
            r_out_hsync <= 1'b1;
            r_out_vsync <= 1'b1;
        end else if (pixel_tick) begin
            r_out_rgb   <= w_rgb_next;
            r_out_hsync <= r_hsync;
            r_out_vsync <= r_vsync;
        end
    end

    assign rgb         = r_out_rgb;
    assign hsync       = r_out_hsync;
    assign vsync       = r_out_vsync;
    assign blink_phase = r_blink_phase;

endmodule
`default_nettype wire

// File: doc/vga_layer_mixer.md
# vga_layer_mixer

Parametrised pixel compositor between the VGA sync generator and the RGB output pins. It takes NUM_LAYERS overlay-enable/colour pairs from the text and graphics generators and merges them by fixed priority into one registered RGB value. Each layer has a selectable mode (opaque, blinking, XOR-invert). It delays hsync/vsync by the same pipeline latency so sync and pixel data stay aligned at the connector.

## Interface
Parameters:
- NUM_LAYERS, 10, number of overlay layers; layer 0 is the bottom, layer NUM_LAYERS-1 is the top.
- COLOR_W, 3, bits per pixel colour.
- BLINK_FRAMES, 30, frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- pixel_tick  in  1  pixel enable, one clk wide; all pipeline registers advance only when it is 1.
- frame_start  in  1  one-clk pulse per frame, asserted once at the start of vertical blank.
- video_on  in  1  visible-area flag from the sync generator.
- hsync_in, vsync_in  in  1 each  raw sync from the sync generator.
- layer_on  in  NUM_LAYERS  per-layer pixel-hit flags.
- layer_rgb  in  NUM_LAYERS*COLOR_W  layer i colour in bits [i*COLOR_W +: COLOR_W].
- layer_mode  in  2*NUM_LAYERS  layer i mode in bits [2i +: 2]: 00 opaque, 01 blink, 10 XOR, 11 disabled.
- bg_rgb  in  COLOR_W  background colour for visible pixels that no layer covers.
- rgb  out  COLOR_W  composited pixel.
- hsync, vsync  out  1 each  delayed sync.
- blink_phase  out  1  current blink state (1 = blinking layers visible).

## Operation
- Stage 1 (on pixel_tick) registers video_on, hsync_in, vsync_in, layer_on, layer_rgb and layer_mode.
- Stage 2 (on pixel_tick) computes the composite from the stage-1 values and registers it to rgb, together with the delayed hsync/vsync.
- Effective hit per layer:
  - mode 00 or 10: on_eff[i] = on[i].
  - mode 01: on_eff[i] = on[i] & blink_phase.
  - mode 11: on_eff[i] = 0.
- Composite runs bottom-up, combinational within stage 2:
  - Start with acc = bg_rgb.
  - For i = 0 up to NUM_LAYERS-1, if on_eff[i]: mode 10 gives acc = acc ^ rgb[i]; any other mode gives acc = rgb[i].
- If stage-1 video_on = 0, rgb_next = 0, regardless of layers and bg_rgb.
- Blink engine:
  - A frame counter, width clog2(BLINK_FRAMES) and minimum 1 bit, increments on each frame_start.
  - At count BLINK_FRAMES-1, a frame_start wraps the counter to 0 and toggles blink_phase.
  - With BLINK_FRAMES = 1, blink_phase toggles on every frame_start.
  - frame_start is sampled on every clk, independent of pixel_tick.
  - blink_phase is read by stage 2 in the same clk, with no extra alignment.
- Reset (asynchronous, low) clears:
  - rgb, all stage-1 data registers and the frame counter to 0.
  - hsync, vsync and the stage-1 sync registers to 1, the inactive level.
  - blink_phase to 1.
- Reset asserted mid-frame forces these values immediately. After reset releases, output becomes valid from the 2nd pixel_tick onward.

## Timing
- Latency: exactly 2 pixel_tick events from input to rgb/hsync/vsync, identical for data and sync.
- Outputs change only on a clk rising edge where pixel_tick = 1. blink_phase is the one exception: it changes on a frame_start edge.
- Inputs need only be stable at the clk edge where pixel_tick = 1.
- Boundary cases:
  - frame_start coinciding with pixel_tick: the counter update and pipeline advance both happen. The pixel composited in that edge uses the pre-toggle blink_phase.
  - All layers off in the visible area: rgb = bg_rgb.
  - Multiple opaque hits: the highest index wins.
  - XOR on the bottom layer combines with bg_rgb.
  - Back-to-back pixel_tick on every clk is supported, giving full-rate operation.

## Test plan
- Reset: hold reset = 0 with random inputs -> rgb = 0, hsync = vsync = 1, blink_phase = 1. Release reset, drive video_on = 1, layer_on = 0, bg_rgb = 3'b001 -> rgb = 001 after the 2nd pixel_tick.
- Priority: layer 2 = 3'b100 and layer 7 = 3'b010, both opaque and on -> rgb = 010. Turn layer 7 off -> rgb = 100 two ticks later.
- XOR: bg = 000, layer 0 opaque 3'b111, layer 3 XOR 3'b101 -> rgb = 010. Layer 3 alone -> rgb = 101.
- Blink: BLINK_FRAMES = 2, layer 1 mode 01 colour 110 on, bg = 000 -> rgb = 110 for 2 frame_starts, then 000 for 2, then 110; blink_phase toggles on every 2nd frame_start.
- Blanking and alignment: toggle video_on, hsync_in and vsync_in with a pixel_tick every 4 clks -> rgb = 0 when blanked. Each output edge lags its input by exactly 2 pixel_ticks. Mode 11 layer on -> never visible.
- Reset mid-operation: assert reset during a blink-off phase with counter = 1 -> outputs reset immediately. Counter = 0 and blink_phase = 1 after release.
